// File: rtl/algo_sram_1r1w_resp_if.sv
// Bus bundle for the 1R1W algorithmic SRAM: write port A, read port B, and the response/status signals.
interface algo_sram_1r1w_resp_if #(
  parameter int WIDTH   = 32,
  parameter int BITSROW = 10
);
  logic               ready;
  logic               writeA;
  logic [BITSROW-1:0] addrA;
  logic [WIDTH-1:0]   dinA;
  logic [WIDTH-1:0]   bwA;
  logic               readB;
  logic [BITSROW-1:0] addrB;
  logic [WIDTH-1:0]   doutB;
  logic               doutB_vld;
  logic               coll;
  logic               aerr;

  modport master (
    input  ready, doutB, doutB_vld, coll, aerr,
    output writeA, addrA, dinA, bwA, readB, addrB
  );

  modport slave (
    output ready, doutB, doutB_vld, coll, aerr,
    input  writeA, addrA, dinA, bwA, readB, addrB
  );
endinterface

// File: rtl/algo_sram_1r1w_resp.sv
// 1R1W SRAM with a zeroing init sweep after reset, bit-write port A and a SRAM_DELAY-deep read
// response pipeline on port B carrying collision and address-range error flags.
module algo_sram_1r1w_resp #(
  parameter int WIDTH      = 32,
  parameter int NUMSROW    = 745,
  parameter int BITSROW    = 10,
  parameter int SRAM_DELAY = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  algo_sram_1r1w_resp_if.slave   bus
);

  localparam logic [BITSROW:0]   LP_NROWS = (BITSROW+1)'(NUMSROW);
  localparam logic [BITSROW-1:0] LP_LAST  = BITSROW'(NUMSROW - 1);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t             r_state;
  logic [BITSROW-1:0] r_cnt;
  logic               r_ready;
  logic [WIDTH-1:0]   r_mem [NUMSROW];

  logic               r_vld_p  [SRAM_DELAY];
  logic               r_coll_p [SRAM_DELAY];
  logic               r_aerr_p [SRAM_DELAY];
  logic [WIDTH-1:0]   r_dat_p  [SRAM_DELAY];

  logic w_run;
  logic w_wr;
  logic w_rd;
  logic w_wr_in;
  logic w_rd_in;
  logic w_err;
  logic w_coll;

  assign w_run   = (r_state == ST_RUN);
  assign w_wr    = w_run & bus.writeA;
  assign w_rd    = w_run & bus.readB;
  assign w_wr_in = ({1'b0, bus.addrA} < LP_NROWS);
  assign w_rd_in = ({1'b0, bus.addrB} < LP_NROWS);
  assign w_err   = (w_wr & ~w_wr_in) | (w_rd & ~w_rd_in);
  // A zero bit-write mask still counts as a write for collision purposes.
  assign w_coll  = w_rd & w_rd_in & w_wr & (bus.addrA == bus.addrB);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_INIT;
      r_cnt   <= '0;
      r_ready <= 1'b0;
    end else begin
      case (r_state)
        ST_INIT: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LP_LAST) begin
            r_state <= ST_RUN;
            r_ready <= 1'b1;
          end
        end
        ST_RUN: begin
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (!w_run) begin
        r_mem[r_cnt] <= '0;
      end else if (w_wr && w_wr_in) begin
        r_mem[bus.addrA] <= (r_mem[bus.addrA] & ~bus.bwA) | (bus.dinA & bus.bwA);
      end
    end
  end

  // Stage 0 samples the array before this edge's write lands, so a same-row read sees old data.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < SRAM_DELAY; k++) begin
        r_vld_p[k]  <= 1'b0;
        r_coll_p[k] <= 1'b0;
        r_aerr_p[k] <= 1'b0;
        r_dat_p[k]  <= '0;
      end
    end else begin
      r_vld_p[0]  <= w_rd;
      r_coll_p[0] <= w_coll;
      r_aerr_p[0] <= w_err;
      if (w_rd) begin
        r_dat_p[0] <= w_rd_in ? r_mem[bus.addrB] : '0;
      end
      // Later stages: data only advances behind a valid, so the output holds between returns.
      for (int k = 1; k < SRAM_DELAY; k++) begin
        r_vld_p[k]  <= r_vld_p[k-1];
        r_coll_p[k] <= r_coll_p[k-1];
        r_aerr_p[k] <= r_aerr_p[k-1];
        if (r_vld_p[k-1]) begin
          r_dat_p[k] <= r_dat_p[k-1];
        end
      end
    end
  end

  assign bus.ready     = r_ready;
  assign bus.doutB     = r_dat_p[SRAM_DELAY-1];
  assign bus.doutB_vld = r_vld_p[SRAM_DELAY-1];
  assign bus.coll      = r_coll_p[SRAM_DELAY-1];
  assign bus.aerr      = r_aerr_p[SRAM_DELAY-1];

endmodule

// File: doc/algo_sram_1r1w_resp.md
ALGO_SRAM_1R1W_RESP -- requirements
Module: algo_sram_1r1w_resp

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning data and bit-write width of one physical row.
REQ-002 SHALL have parameter NUMSROW, default 745, meaning number of physical rows.
REQ-003 SHALL have parameter BITSROW, default 10, meaning row address width.
REQ-004 SHALL have parameter SRAM_DELAY, default 1, legal range 1..4, meaning read latency in cycles.
REQ-005 SHALL provide the following ports, one per line: name, direction, width, meaning.
- clk  input  1  single clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- ready  output  1  high once the init sweep is complete.
- writeA  input  1  port A write strobe.
- addrA  input  BITSROW  port A row address.
- dinA  input  WIDTH  port A write data.
- bwA  input  WIDTH  port A bit-write enables, 1 = write this bit.
- readB  input  1  port B read strobe.
- addrB  input  BITSROW  port B row address.
- doutB  output  WIDTH  port B read data.
- doutB_vld  output  1  doutB carries data for a read issued SRAM_DELAY cycles earlier.
- coll  output  1  the returned read collided with a same-cycle, same-row write.
- aerr  output  1  the returned read, or a same-cycle write, addressed a row >= NUMSROW.

Function
REQ-006 SHALL implement a two-state FSM, INIT and RUN; rst forces INIT with init counter 0.
REQ-007 In INIT, SHALL write all-zero to row = counter each cycle, incrementing the counter by 1, and SHALL ignore writeA and readB.
REQ-008 SHALL transition INIT->RUN in the cycle after the counter writes row NUMSROW-1, so INIT lasts exactly NUMSROW cycles after rst deasserts.
REQ-009 ready SHALL be 0 in INIT and 1 in RUN; ready is registered.
REQ-010 In RUN with writeA=1 and addrA<NUMSROW, SHALL update row addrA to (old & ~bwA) | (dinA & bwA) at the clock edge.
REQ-011 In RUN with readB=1 and addrB<NUMSROW, SHALL sample row addrB at the edge and present it on doutB with doutB_vld=1 exactly SRAM_DELAY cycles later.
REQ-012 Reads and writes SHALL be fully pipelined: one read and one write accepted every cycle; back-to-back reads return back-to-back with no bubbles.
REQ-013 Same-cycle read and write to the same row SHALL return pre-write (old) data and SHALL assert coll with that read's doutB_vld.
REQ-014 A read issued the cycle after a write to the same row SHALL return the new data.
REQ-015 A write with addrA>=NUMSROW SHALL NOT modify any row and SHALL pulse aerr for one cycle, SRAM_DELAY cycles later.
REQ-016 A read with addrB>=NUMSROW SHALL return doutB=0 with doutB_vld=1 and aerr=1.
REQ-017 When no read returns in a cycle, doutB SHALL hold its last value, and doutB_vld, coll and aerr SHALL be 0.
REQ-018 bwA=0 with writeA=1 SHALL leave the row unchanged and SHALL still count as a write for coll.

Reset
REQ-019 SHALL take the following values during rst: ready=0, doutB=0, doutB_vld=0, coll=0, aerr=0; all SRAM_DELAY pipeline stages are cleared.
REQ-020 rst asserted mid-operation SHALL drop all in-flight reads with no doutB_vld, abandon RUN, and restart the full INIT sweep from row 0.
REQ-021 rst asserted during INIT SHALL restart the counter at 0.

Verification
REQ-022 The bench SHALL cover the following directed scenarios, one per line: stimulus -> required response.
- Init: NUMSROW=745, release rst -> ready rises exactly 745 cycles later; a read of row 744 returns 0.
- Bit-write: row 5 holds 0xFFFF0000; write dinA=0x12345678, bwA=0x0000FFFF -> read returns 0xFFFF5678 after SRAM_DELAY.
- Collision: row 7=0xA, same-cycle write 0xB and read of row 7 -> doutB=0xA, coll=1; next-cycle read -> 0xB, coll=0.
- Streaming: SRAM_DELAY=3, reads of rows 0..9 on consecutive cycles -> ten consecutive doutB_vld pulses starting 3 cycles after the first read, data in order.
- Range: read addrB=1000 -> doutB=0, aerr=1; write addrA=1000 -> no row changed, aerr pulse.
- Mid-reset: rst asserted with two reads in flight -> no doutB_vld; ready=0 for 745 cycles; previously written rows read back 0.
